// File: rtl/paillier_axi_full_ram_slave.sv
// AXI4-Full slave over a register-array memory; INCR-only, one transaction per direction.
// Latency: RVALID one cycle after AR handshake, W beats back-to-back, BVALID the cycle after WLAST.
// Backpressure: R and B outputs held until ready; PAILLIER_RAM_RAND_STALL_EN adds LFSR stalls.
module paillier_axi_full_ram_slave #(
    parameter int          C_S_AXI_ID_WIDTH   = 1,
    parameter int          C_S_AXI_ADDR_WIDTH = 64,
    parameter int          C_S_AXI_DATA_WIDTH = 64,
    parameter int          MEM_DEPTH          = 1024,
    parameter logic [63:0] BASE_ADDR          = 64'h0
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [7:0]                        S_AXI_AWLEN,
    input  logic [2:0]                        S_AXI_AWSIZE,
    input  logic [1:0]                        S_AXI_AWBURST,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WLAST,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [7:0]                        S_AXI_ARLEN,
    input  logic [2:0]                        S_AXI_ARSIZE,
    input  logic [1:0]                        S_AXI_ARBURST,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RLAST,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int LP_BYTES = DW / 8;
    localparam int LP_LSB   = $clog2(LP_BYTES);
    localparam int LP_IDXW  = $clog2(MEM_DEPTH);
    localparam logic [AW-1:0] LP_BASE   = AW'(BASE_ADDR);
    localparam logic [AW-1:0] LP_STRIDE = AW'(LP_BYTES);
    localparam logic [AW-1:0] LP_DEPTH  = AW'(MEM_DEPTH);
    localparam logic [1:0]    LP_OKAY   = 2'b00;
    localparam logic [1:0]    LP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA} rstate_t;

    // Borrow bit of the subtraction catches addresses below the window.
    function automatic logic f_in_range(input logic [AW-1:0] a);
        logic [AW:0] diff;
        diff = {1'b0, a} - {1'b0, LP_BASE};
        return !diff[AW] && ((diff[AW-1:0] >> LP_LSB) < LP_DEPTH);
    endfunction

    function automatic logic [LP_IDXW-1:0] f_idx(input logic [AW-1:0] a);
        return LP_IDXW'((a - LP_BASE) >> LP_LSB);
    endfunction

    logic [DW-1:0] r_mem [MEM_DEPTH];

    wstate_t                      r_wstate, w_wstate_nxt;
    rstate_t                      r_rstate, w_rstate_nxt;
    logic                         r_alive;
    logic [C_S_AXI_ID_WIDTH-1:0]  r_awid, r_arid;
    logic [AW-1:0]                r_awaddr, r_araddr;
    logic [7:0]                   r_awlen, r_arlen, r_rbeat;
    logic [8:0]                   r_wbeat;
    logic                         r_werr;
    logic [DW-1:0]                r_rdata;
    logic [1:0]                   r_rresp;
    logic                         r_rlast, r_rvalid;

    logic w_stall_aw, w_stall_w, w_stall_ar, w_stall_rv;
`ifdef PAILLIER_RAM_RAND_STALL_EN
    localparam logic LP_RV_IMM = 1'b0;
    logic [15:0] r_lfsr;
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) r_lfsr <= 16'hACE1;
        else                r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
    assign w_stall_aw = r_lfsr[0];
    assign w_stall_w  = r_lfsr[1];
    assign w_stall_ar = r_lfsr[2];
    assign w_stall_rv = r_lfsr[3];
`else
    localparam logic LP_RV_IMM = 1'b1;
    assign w_stall_aw = 1'b0;
    assign w_stall_w  = 1'b0;
    assign w_stall_ar = 1'b0;
    assign w_stall_rv = 1'b0;
`endif

    logic w_unused;
    assign w_unused = ^{S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_ARSIZE, S_AXI_ARBURST, w_stall_rv};

    logic w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
    assign w_aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign w_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    assign w_r_hs  = r_rvalid      && S_AXI_RREADY;

    // Readies stay low until the first edge after reset release.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) r_alive <= 1'b0;
        else                r_alive <= 1'b1;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) r_wstate <= W_IDLE;
        else                r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs && S_AXI_WLAST) w_wstate_nxt = W_RESP;
            W_RESP:  if (S_AXI_BREADY) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        case (r_wstate)
            W_IDLE:  S_AXI_AWREADY = r_alive && !w_stall_aw;
            W_DATA:  S_AXI_WREADY  = !w_stall_w;
            W_RESP:  S_AXI_BVALID  = 1'b1;
            default: ;
        endcase
    end

    logic                w_w_inr, w_w_commit;
    logic [LP_IDXW-1:0]  w_widx;
    assign w_w_inr    = f_in_range(r_awaddr);
    assign w_widx     = f_idx(r_awaddr);
    assign w_w_commit = w_w_hs && w_w_inr && (r_wbeat <= {1'b0, r_awlen});

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_awid   <= '0;
            r_awaddr <= '0;
            r_awlen  <= '0;
            r_wbeat  <= '0;
            r_werr   <= 1'b0;
        end else if (w_aw_hs) begin
            r_awid   <= S_AXI_AWID;
            r_awaddr <= S_AXI_AWADDR;
            r_awlen  <= S_AXI_AWLEN;
            r_wbeat  <= '0;
            r_werr   <= 1'b0;
        end else if (w_w_hs) begin
            r_awaddr <= r_awaddr + LP_STRIDE;
            if (!r_wbeat[8]) r_wbeat <= r_wbeat + 9'd1;
            if (!w_w_inr || (S_AXI_WLAST && (r_wbeat != {1'b0, r_awlen}))) r_werr <= 1'b1;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (w_w_commit) begin
            for (int b = 0; b < LP_BYTES; b++) begin
                if (S_AXI_WSTRB[b]) r_mem[w_widx][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
            end
        end
    end

    assign S_AXI_BID   = r_awid;
    assign S_AXI_BRESP = r_werr ? LP_SLVERR : LP_OKAY;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) r_rstate <= R_IDLE;
        else                r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_ARREADY = 1'b0;
        if (r_rstate == R_IDLE) S_AXI_ARREADY = r_alive && !w_stall_ar;
    end

    // Sample address is the AR address when idle, else the next beat's address.
    logic [AW-1:0] w_rnext, w_rsrc;
    logic          w_rsrc_inr;
    logic [DW-1:0] w_rsrc_dat;
    assign w_rnext    = r_araddr + LP_STRIDE;
    assign w_rsrc     = (r_rstate == R_IDLE) ? S_AXI_ARADDR : w_rnext;
    assign w_rsrc_inr = f_in_range(w_rsrc);
    assign w_rsrc_dat = w_rsrc_inr ? r_mem[f_idx(w_rsrc)] : '0;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_arid   <= '0;
            r_araddr <= '0;
            r_arlen  <= '0;
            r_rbeat  <= '0;
            r_rdata  <= '0;
            r_rresp  <= LP_OKAY;
            r_rlast  <= 1'b0;
            r_rvalid <= 1'b0;
        end else begin
            if (r_rstate == R_DATA && !r_rvalid && !w_stall_rv) r_rvalid <= 1'b1;
            if (w_ar_hs) begin
                r_arid   <= S_AXI_ARID;
                r_araddr <= S_AXI_ARADDR;
                r_arlen  <= S_AXI_ARLEN;
                r_rbeat  <= '0;
                r_rdata  <= w_rsrc_dat;
                r_rresp  <= w_rsrc_inr ? LP_OKAY : LP_SLVERR;
                r_rlast  <= (S_AXI_ARLEN == 8'd0);
                r_rvalid <= LP_RV_IMM;
            end else if (w_r_hs) begin
                if (r_rlast) begin
                    r_rvalid <= 1'b0;
                    r_rlast  <= 1'b0;
                end else begin
                    r_araddr <= w_rnext;
                    r_rbeat  <= r_rbeat + 8'd1;
                    r_rdata  <= w_rsrc_dat;
                    r_rresp  <= w_rsrc_inr ? LP_OKAY : LP_SLVERR;
                    r_rlast  <= ((r_rbeat + 8'd1) == r_arlen);
                end
            end
        end
    end

    assign S_AXI_RID    = r_arid;
    assign S_AXI_RDATA  = r_rdata;
    assign S_AXI_RRESP  = r_rresp;
    assign S_AXI_RLAST  = r_rlast;
    assign S_AXI_RVALID = r_rvalid;
endmodule

// File: tb/tb_paillier_axi_full_ram_slave.sv
// Directed and randomized bench for paillier_axi_full_ram_slave against an array-based memory model.
`timescale 1ns/1ps
module tb_paillier_axi_full_ram_slave;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:0]  awid, bid, arid, rid;
    logic [63:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    always #5 clk = ~clk;

    paillier_axi_full_ram_slave dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
        .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready), .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready), .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    logic [63:0] mdl [1024];
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_inr(input logic [63:0] a);
        return (a >> 3) < 64'd1024;
    endfunction

    // Model: beat i targets addr+8*i; written when in range and i <= len.
    task automatic wr_burst(input logic id, input logic [63:0] addr, input int len, input int nbeats,
                            input bit rnd, input logic [63:0] d0, input logic [63:0] dinc,
                            input logic [7:0] strb);
        int cnt;
        bit err;
        logic [63:0] a, d;
        logic [7:0]  s;
        err = (nbeats - 1 != len);
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len[7:0]; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
        cnt = 0;
        while (!awready && cnt < 1000) begin @(negedge clk); cnt++; end
        if (cnt >= 1000) check("aw_timeout", 0, 1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge clk); end
            a = addr + 64'(8 * i);
            d = rnd ? {$urandom, $urandom} : d0 + dinc * 64'(i);
            s = rnd ? 8'($urandom) : strb;
            wdata = d; wstrb = s; wlast = (i == nbeats - 1); wvalid = 1'b1;
            if (!m_inr(a)) err = 1'b1;
            else if (i <= len)
                for (int b = 0; b < 8; b++) if (s[b]) mdl[a[12:3]][b*8 +: 8] = d[b*8 +: 8];
            cnt = 0;
            while (!wready && cnt < 1000) begin @(negedge clk); cnt++; end
            if (cnt >= 1000) check("w_timeout", 0, 1);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        cnt = 0;
        while (cnt < 1000) begin
            bready = rnd ? 1'($urandom) : 1'b1;
            if (bvalid && bready) break;
            @(negedge clk); cnt++;
        end
        if (cnt >= 1000) check("b_timeout", 0, 1);
        else begin
            check("bid", bid, id);
            check("bresp", bresp, err ? 2'b10 : 2'b00);
        end
        @(negedge clk);
        bready = 1'b0;
    endtask

    // rmode 0: RREADY high, 1: toggles every cycle, 2: random. Returns early after abort_at beats.
    task automatic rd_burst(input logic id, input logic [63:0] addr, input int len, input int rmode,
                            input int abort_at);
        int cnt, beat;
        bit held;
        logic [63:0] a, h_dat;
        logic [1:0]  h_resp;
        logic        h_last;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len[7:0]; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
        cnt = 0;
        while (!arready && cnt < 1000) begin @(negedge clk); cnt++; end
        if (cnt >= 1000) check("ar_timeout", 0, 1);
        @(negedge clk);
        arvalid = 1'b0;
        check("r_latency", rvalid, 1);
        beat = 0; cnt = 0; held = 0; h_dat = '0; h_resp = '0; h_last = 0;
        while (beat <= len && cnt < 5000) begin
            case (rmode)
                0:       rready = 1'b1;
                1:       rready = (cnt % 2 == 0);
                default: rready = 1'($urandom);
            endcase
            if (held) begin
                check("r_hold_vld", rvalid, 1);
                check("r_hold_dat", rdata, h_dat);
                check("r_hold_ctl", {rresp, rlast}, {h_resp, h_last});
            end
            if (rvalid && rready) begin
                a = addr + 64'(8 * beat);
                check("rdata", rdata, m_inr(a) ? mdl[a[12:3]] : 64'h0);
                check("rresp", rresp, m_inr(a) ? 2'b00 : 2'b10);
                check("rlast", rlast, beat == len);
                check("rid", rid, id);
                beat++;
                if (beat == abort_at) break;
            end
            held = rvalid && !rready;
            h_dat = rdata; h_resp = rresp; h_last = rlast;
            @(negedge clk); cnt++;
        end
        if (cnt >= 5000) check("r_timeout", 0, 1);
        rready = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [63:0] ra;
        int rl;
        logic rid_r;
        rst_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_arready", arready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rlast", rlast, 0);
        check("rst_resp_ids", {bresp, rresp, bid, rid}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_awready", awready, 1);
        check("post_rst_arready", arready, 1);

        for (int k = 0; k < 4; k++) wr_burst(1'b0, 64'(k * 2048), 255, 256, 1'b1, 0, 0, 8'hFF);

        wr_burst(1'b0, 64'h0, 0, 1, 1'b0, 64'h1122334455667788, 0, 8'hFF);
        rd_burst(1'b0, 64'h0, 0, 0, -1);

        wr_burst(1'b0, 64'h100, 15, 16, 1'b0, 64'h0, 64'h1, 8'hFF);
        rd_burst(1'b0, 64'h100, 15, 1, -1);

        wr_burst(1'b0, 64'h40, 0, 1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 8'hFF);
        wr_burst(1'b0, 64'h40, 0, 1, 1'b0, 64'h0, 0, 8'h0F);
        rd_burst(1'b0, 64'h40, 0, 0, -1);

        wr_burst(1'b1, 64'h2000, 0, 1, 1'b0, 64'hDEAD_BEEF_0BAD_F00D, 0, 8'hFF);
        rd_burst(1'b1, 64'h2000, 0, 0, -1);
        rd_burst(1'b0, 64'h0, 0, 0, -1);
        wr_burst(1'b0, 64'h1FF0, 3, 4, 1'b0, 64'hA5A5_0000_0000_0000, 64'h1, 8'hFF);
        rd_burst(1'b0, 64'h1FF0, 3, 2, -1);

        fork
            wr_burst(1'b0, 64'h200, 3, 4, 1'b1, 0, 0, 8'hFF);
            rd_burst(1'b1, 64'h300, 3, 2, -1);
        join
        rd_burst(1'b0, 64'h200, 3, 0, -1);

        wr_burst(1'b1, 64'h500, 3, 2, 1'b0, 64'h5000, 64'h1, 8'hFF);
        wr_burst(1'b0, 64'h600, 1, 3, 1'b0, 64'h6000, 64'h1, 8'hFF);
        rd_burst(1'b0, 64'h500, 3, 0, -1);
        rd_burst(1'b1, 64'h600, 2, 0, -1);

        rd_burst(1'b0, 64'h400, 7, 0, 2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rvalid", rvalid, 0);
        check("midrst_arready", arready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_burst(1'b1, 64'h400, 7, 0, -1);

        for (int it = 0; it < 25; it++) begin
            ra = 64'($urandom_range(0, 1040)) << 3;
            rl = $urandom_range(0, 7);
            rid_r = 1'($urandom);
            wr_burst(rid_r, ra, rl, rl + 1, 1'b1, 0, 0, 8'hFF);
            rd_burst(~rid_r, ra, rl, 2, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/paillier_axi_full_ram_slave.md
Name: paillier_axi_full_ram_slave

Overview:
Synthesizable AXI4-Full slave responder backed by an on-chip register-array memory. It is the memory-side end of the Paillier core's AXI-Full master port: it serves operand/key burst reads and accepts result burst writes. It replaces the behavioural memory model in FPGA bring-up builds and is also instantiable in simulation.

Parameters:
C_S_AXI_ID_WIDTH, 1, AXI ID width
C_S_AXI_ADDR_WIDTH, 64, byte address width
C_S_AXI_DATA_WIDTH, 64, data width in bits; power of 2, >= 32
MEM_DEPTH, 1024, words; power of 2
BASE_ADDR, 64'h0, byte base address of the memory window

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  reset, asynchronous, active-low
S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in  ID/ADDR/8/3/2/1  write address channel
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA/WSTRB/WLAST/WVALID  in  DATA/DATA/8/1/1  write data channel
S_AXI_WREADY  out  1  write data ready
S_AXI_BID/BRESP/BVALID  out  ID/2/1  write response
S_AXI_BREADY  in  1  write response ready
S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  ID/ADDR/8/3/2/1  read address channel
S_AXI_ARREADY  out  1  read address ready
S_AXI_RID/RDATA/RRESP/RLAST/RVALID  out  ID/DATA/2/1/1  read data channel
S_AXI_RREADY  in  1  read data ready

Behaviour:
- Reset (async assert, sync release): every output 0; both FSMs idle. Memory contents are not reset. Reset mid-burst abandons the burst, with no further writes or responses.
- Word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). A beat is out of range if addr < BASE_ADDR or index >= MEM_DEPTH.
- AxSIZE is ignored; the beat stride is always DATA_WIDTH/8. AxBURST is ignored; all bursts are treated as INCR with no 4 KB check.
- Write FSM: W_IDLE -> W_DATA -> W_RESP.
  - W_IDLE: AWREADY=1. On AW handshake, latch ID, address and length, clear the beat counter, and go to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes mem[idx] byte-wise per WSTRB, provided the beat is in range and beat <= AWLEN. Address increments by one word per beat.
  - On a handshake with WLAST=1, go to W_RESP.
  - W_RESP: BVALID=1 and BID=latched ID. Hold until BREADY, then return to W_IDLE.
  - BRESP=SLVERR(2'b10) if any beat was out of range or WLAST arrived at beat != AWLEN; otherwise OKAY.
- Read FSM: R_IDLE -> R_DATA.
  - R_IDLE: ARREADY=1. On AR handshake, latch ID and length, and register RDATA=mem[idx(ARADDR)].
  - R_DATA: RVALID=1 from the cycle after the AR handshake (latency 1). RID=latched ID. RLAST=1 when beat==ARLEN.
  - RRESP=SLVERR with RDATA=0 for out-of-range beats, else OKAY.
  - On R handshake: if not last, increment the address and register the next word, so RVALID stays high with no bubble. If last, clear RVALID/RLAST and return to R_IDLE.
  - RVALID, RDATA, RRESP and RLAST are held stable while RREADY=0.
- Read and write channels are fully independent and may run concurrently. If a read sample and a write commit hit the same word in the same cycle, the read returns the pre-write data.
- One outstanding transaction per direction; no interleaving or reordering.

Optional Feature:
- Macro PAILLIER_RAM_RAND_STALL_EN.
  - Defined: a 16-bit LFSR (seed 16'hACE1, reset value) gates AWREADY, WREADY and ARREADY, and delays RVALID assertion. Each ready or valid is suppressed in any cycle where its assigned LFSR bit is 1 (bits 0/1/2/3 respectively). An RVALID already asserted is never withdrawn.
  - Undefined: no stalls; timing is exactly as in Behaviour.

Test Plan:
- Single write then read: AW addr 0x0, len 0, WDATA 64'h1122334455667788, WSTRB 8'hFF -> BRESP OKAY. AR addr 0x0 -> RVALID 1 cycle after handshake, RDATA 64'h1122334455667788, RLAST=1.
- 16-beat INCR write (AWLEN=15, data=beat index) at 0x100, then 16-beat read with RREADY toggled every other cycle -> data 0..15 in order, RLAST only on beat 15, data stable while stalled.
- Partial strobe: write 64'hFFFF_FFFF_FFFF_FFFF, then 64'h0 with WSTRB 8'h0F -> read returns 64'hFFFF_FFFF_0000_0000.
- Out of range: MEM_DEPTH=1024, write at 0x2000 -> BRESP SLVERR, memory unchanged. Read there -> RRESP SLVERR, RDATA 0.
- Concurrent traffic: 4-beat read and 4-beat write to disjoint addresses issued the same cycle -> both complete with correct data and IDs (ARID=1, AWID=0).
- Reset mid-read (ARESETN low at beat 2 of 8) -> RVALID/ARREADY 0 immediately. After release, a new read returns correct data.
